// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, flush-to-bubble, WB write-through
// bypass on both source operands, and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_read_data_1,
  input  logic [XLEN-1:0]    id_read_data_2,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_alu_src,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_branch,
  input  logic               id_jump,
  input  logic               wb_reg_write,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [XLEN-1:0]    wb_write_data,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_read_data_1,
  output logic [XLEN-1:0]    ex_read_data_2,
  output logic [XLEN-1:0]    ex_imm,
  output logic [REG_AW-1:0]  ex_rs1,
  output logic [REG_AW-1:0]  ex_rs2,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic [CNT_W-1:0]   bubble_count
);

  logic            bypass_1;
  logic            bypass_2;
  logic [XLEN-1:0] fwd_data_1;
  logic [XLEN-1:0] fwd_data_2;

  // x0 is hardwired to zero, so a WB "write" to it must never reach EX
  assign bypass_1   = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
  assign bypass_2   = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);
  assign fwd_data_1 = bypass_1 ? wb_write_data : id_read_data_1;
  assign fwd_data_2 = bypass_2 ? wb_write_data : id_read_data_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_read_data_1 <= '0;
      ex_read_data_2 <= '0;
      ex_imm         <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_alu_src     <= 1'b0;
      ex_alu_op      <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jump        <= 1'b0;
      bubble_count   <= '0;
    end else if (flush) begin
      // A bubble is an all-zero word so downstream logic sees no stray state
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_read_data_1 <= '0;
      ex_read_data_2 <= '0;
      ex_imm         <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_alu_src     <= 1'b0;
      ex_alu_op      <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jump        <= 1'b0;
      if (bubble_count != '1) begin
        bubble_count <= bubble_count + CNT_W'(1);
      end
    end else if (!stall) begin
      ex_valid       <= id_valid;
      ex_pc          <= id_pc;
      ex_read_data_1 <= fwd_data_1;
      ex_read_data_2 <= fwd_data_2;
      ex_imm         <= id_imm;
      ex_rs1         <= id_rs1;
      ex_rs2         <= id_rs2;
      ex_rd          <= id_rd;
      ex_alu_src     <= id_alu_src;
      ex_alu_op      <= id_alu_op;
      // Side-effecting controls of an invalid slot are squashed here
      ex_reg_write   <= id_reg_write & id_valid;
      ex_mem_read    <= id_mem_read  & id_valid;
      ex_mem_write   <= id_mem_write & id_valid;
      ex_mem_to_reg  <= id_mem_to_reg;
      ex_branch      <= id_branch    & id_valid;
      ex_jump        <= id_jump      & id_valid;
    end
  end

endmodule
